// File: rtl/prio_intr_ctrl.sv
// Priority interrupt controller with an APB-style register port.
// Per-channel enable, edge/level mode and priority, a global threshold,
// round-robin among equal priorities and an IDLE/SERVICE/DONE service FSM.
module prio_intr_ctrl #(
    parameter int unsigned NUM_INTR = 16,
    parameter int unsigned PRIO_W   = 4,
    parameter int unsigned ID_W     = $clog2(NUM_INTR)
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    input  logic [7:0]          paddr_i,
    input  logic [7:0]          pwdata_i,
    input  logic                pwrite_i,
    input  logic                penable_i,
    output logic [7:0]          prdata_o,
    output logic                pready_o,
    output logic                perror_o,
    input  logic [NUM_INTR-1:0] intr_active_i,
    input  logic                intr_serviced_i,
    output logic [ID_W-1:0]     intr_to_service_o,
    output logic                intr_valid_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StService = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    localparam logic [7:0] AddrThresh = 8'h80;
    localparam logic [7:0] AddrStatus = 8'h81;
    localparam logic [7:0] NumIntrB   = 8'(NUM_INTR);
    localparam logic [ID_W-1:0] LastIdRst = ID_W'(NUM_INTR - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRIO_W-1:0]   prio_q [NUM_INTR];
    logic [NUM_INTR-1:0] edge_mode_q;
    logic [NUM_INTR-1:0] en_q;
    logic [PRIO_W-1:0]   thresh_q;

    logic [NUM_INTR-1:0] act_q;
    logic [NUM_INTR-1:0] pending_q, pending_d;

    logic [1:0]          state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                valid_q, valid_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;

    logic [7:0]          prdata_q, prdata_d;
    logic                pready_q;
    logic                perror_q, perror_d;

    // ------------------------------------------------------------------
    // Register port decode
    // ------------------------------------------------------------------
    logic            access;
    logic            cfg_hit;
    logic [ID_W-1:0] cfg_idx;
    logic            cfg_we;
    logic            thresh_we;

    // Only the first cycle of a held penable executes; pready blocks the next.
    assign access    = penable_i & ~pready_q;
    assign cfg_hit   = (paddr_i < NumIntrB);
    assign cfg_idx   = paddr_i[ID_W-1:0];
    assign cfg_we    = access & pwrite_i & cfg_hit;
    assign thresh_we = access & pwrite_i & (paddr_i == AddrThresh);

    // Upper write-data bits beyond the priority field are intentionally ignored.
    logic unused_pwdata;
    assign unused_pwdata = ^pwdata_i;

    // Read data and error decode for the access executing this cycle
    always_comb begin
        prdata_d = '0;
        perror_d = 1'b0;
        if (cfg_hit) begin
            if (!pwrite_i) begin
                prdata_d[PRIO_W-1:0] = prio_q[cfg_idx];
                prdata_d[6]          = edge_mode_q[cfg_idx];
                prdata_d[7]          = en_q[cfg_idx];
            end
        end else if (paddr_i == AddrThresh) begin
            if (!pwrite_i) begin
                prdata_d[PRIO_W-1:0] = thresh_q;
            end
        end else if (paddr_i == AddrStatus) begin
            if (pwrite_i) begin
                perror_d = 1'b1;
            end else begin
                prdata_d[7]        = valid_q;
                prdata_d[ID_W-1:0] = id_q;
            end
        end else begin
            perror_d = 1'b1;
        end
    end

    // Access-complete pulse and registered response
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
            perror_q <= 1'b0;
        end else begin
            pready_q <= access;
            if (access) begin
                prdata_q <= prdata_d;
                perror_q <= perror_d;
            end
        end
    end

    // Configuration registers written from the register port
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            for (int unsigned i = 0; i < NUM_INTR; i++) begin
                prio_q[i] <= '0;
            end
            edge_mode_q <= '0;
            en_q        <= '0;
            thresh_q    <= '0;
        end else begin
            if (cfg_we) begin
                prio_q[cfg_idx]      <= pwdata_i[PRIO_W-1:0];
                edge_mode_q[cfg_idx] <= pwdata_i[6];
                en_q[cfg_idx]        <= pwdata_i[7];
            end
            if (thresh_we) begin
                thresh_q <= pwdata_i[PRIO_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending tracking
    // ------------------------------------------------------------------
    logic service_done;

    // Level channels follow the line; edge channels latch a rise until serviced
    always_comb begin
        pending_d = '0;
        for (int unsigned i = 0; i < NUM_INTR; i++) begin
            if (edge_mode_q[i]) begin
                // A rise coinciding with completion keeps the channel pending.
                pending_d[i] = (intr_active_i[i] & ~act_q[i]) |
                               (pending_q[i] & ~(service_done & (id_q == ID_W'(i))));
            end else begin
                pending_d[i] = intr_active_i[i];
            end
        end
    end

    // Line history for edge detection and pending flags
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            act_q     <= '0;
            pending_q <= '0;
        end else begin
            act_q     <= intr_active_i;
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_INTR-1:0] eligible;
    logic [NUM_INTR-1:0] cand;
    logic [PRIO_W-1:0]   max_prio;
    logic                win_found;
    logic [ID_W-1:0]     win_id;

    // Highest eligible priority, then round-robin from last_id+1 among ties
    always_comb begin
        eligible  = '0;
        cand      = '0;
        max_prio  = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < NUM_INTR; i++) begin
            eligible[i] = pending_q[i] & en_q[i] & (prio_q[i] > thresh_q);
        end
        for (int unsigned i = 0; i < NUM_INTR; i++) begin
            if (eligible[i] && (prio_q[i] > max_prio)) begin
                max_prio = prio_q[i];
            end
        end
        for (int unsigned i = 0; i < NUM_INTR; i++) begin
            cand[i] = eligible[i] & (prio_q[i] == max_prio);
        end
        for (int unsigned k = 0; k < NUM_INTR; k++) begin
            automatic int unsigned idx;
            idx = 32'(last_id_q) + 32'd1 + k;
            if (idx >= NUM_INTR) begin
                idx = idx - NUM_INTR;
            end
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Service FSM
    // ------------------------------------------------------------------
    // Grant in IDLE, hold until acknowledged, one settling cycle in DONE
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        valid_d      = valid_q;
        last_id_d    = last_id_q;
        service_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    id_d    = win_id;
                    valid_d = 1'b1;
                    state_d = StService;
                end
            end
            StService: begin
                if (intr_serviced_i) begin
                    service_done = 1'b1;
                    valid_d      = 1'b0;
                    last_id_d    = id_q;
                    state_d      = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, granted id and round-robin pointer
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q   <= StIdle;
            id_q      <= '0;
            valid_q   <= 1'b0;
            last_id_q <= LastIdRst;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            last_id_q <= last_id_d;
        end
    end

    assign prdata_o          = prdata_q;
    assign pready_o          = pready_q;
    assign perror_o          = perror_q;
    assign intr_to_service_o = id_q;
    assign intr_valid_o      = valid_q;

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// Directed bench for prio_intr_ctrl: arbitration order, thresholds,
// edge re-pend, register port errors, reset and latency.
module tb_prio_intr_ctrl;

    logic        pclk = 1'b0;
    logic        prst;
    logic [7:0]  paddr;
    logic [7:0]  pwdata;
    logic        pwrite;
    logic        penable;
    logic [7:0]  prdata;
    logic        pready;
    logic        perror;
    logic [15:0] intr_active;
    logic        intr_serviced;
    logic [3:0]  intr_to_service;
    logic        intr_valid;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [7:0] rd;
    logic       er;

    prio_intr_ctrl #(
        .NUM_INTR (16),
        .PRIO_W   (4)
    ) dut (
        .pclk_i            (pclk),
        .prst_i            (prst),
        .paddr_i           (paddr),
        .pwdata_i          (pwdata),
        .pwrite_i          (pwrite),
        .penable_i         (penable),
        .prdata_o          (prdata),
        .pready_o          (pready),
        .perror_o          (perror),
        .intr_active_i     (intr_active),
        .intr_serviced_i   (intr_serviced),
        .intr_to_service_o (intr_to_service),
        .intr_valid_o      (intr_valid)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic do_reset();
        prst = 1'b1;
        tick();
        prst = 1'b0;
    endtask

    // One access, then an idle cycle so the next access is not blocked by pready.
    task automatic apb(input logic [7:0] a, input logic [7:0] wd, input logic wr,
                       output logic [7:0] rdata, output logic err);
        paddr   = a;
        pwdata  = wd;
        pwrite  = wr;
        penable = 1'b1;
        tick();
        chk("pready", {31'd0, pready}, 32'd1);
        rdata   = prdata;
        err     = perror;
        penable = 1'b0;
        pwrite  = 1'b0;
        tick();
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] wd);
        logic [7:0] d;
        logic       e;
        apb(a, wd, 1'b1, d, e);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp_id);
        for (int n = 0; n < 40; n++) begin
            if (intr_valid) break;
            tick();
        end
        chk({tag, "_valid"}, {31'd0, intr_valid}, 32'd1);
        chk({tag, "_id"}, {28'd0, intr_to_service}, {28'd0, exp_id});
    endtask

    // Acknowledge and drop the given level lines at the same edge.
    task automatic ack_clear(input logic [15:0] mask);
        intr_serviced = 1'b1;
        intr_active   = intr_active & ~mask;
        tick();
        intr_serviced = 1'b0;
        chk("ack_drop", {31'd0, intr_valid}, 32'd0);
    endtask

    task automatic no_grant(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (intr_valid) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        prst          = 1'b1;
        paddr         = '0;
        pwdata        = '0;
        pwrite        = 1'b0;
        penable       = 1'b0;
        intr_active   = '0;
        intr_serviced = 1'b0;
        tick();
        tick();
        prst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, intr_valid}, 32'd0);
        chk("rst_id", {28'd0, intr_to_service}, 32'd0);
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_perror", {31'd0, perror}, 32'd0);
        chk("rst_prdata", {24'd0, prdata}, 32'd0);
        apb(8'h81, 8'h00, 1'b0, rd, er);
        chk("rst_status", {24'd0, rd}, 32'h00);

        // Level channels prio=i, lines 0,5,10,15 -> 15, 10, 5
        for (int i = 0; i < 16; i++) wr_reg(8'(i), 8'h80 | 8'(i));
        wr_reg(8'h80, 8'h00);
        intr_active = 16'h8421;
        tick();
        chk("lat_k", {31'd0, intr_valid}, 32'd0);
        tick();
        chk("lat_k1_valid", {31'd0, intr_valid}, 32'd1);
        chk("lat_k1_id", {28'd0, intr_to_service}, 32'd15);
        apb(8'h81, 8'h00, 1'b0, rd, er);
        chk("status_svc", {24'd0, rd}, 32'h8F);
        chk("status_err", {31'd0, er}, 32'd0);
        apb(8'h81, 8'h55, 1'b1, rd, er);
        chk("status_wr_err", {31'd0, er}, 32'd1);
        apb(8'h81, 8'h00, 1'b0, rd, er);
        chk("status_unchg", {24'd0, rd}, 32'h8F);
        ack_clear(16'h8000);
        tick();
        chk("ack_m1", {31'd0, intr_valid}, 32'd0);
        tick();
        chk("ack_m2_valid", {31'd0, intr_valid}, 32'd1);
        chk("ack_m2_id", {28'd0, intr_to_service}, 32'd10);
        ack_clear(16'h0400);
        wait_grant("lvl_g3", 4'd5);
        ack_clear(16'h0020);
        no_grant("prio0_never", 20);
        intr_active = '0;

        // Edge channels 2,5,9 at prio 3; re-pulse 2 at its own ack
        do_reset();
        wr_reg(8'd2, 8'hC3);
        wr_reg(8'd5, 8'hC3);
        wr_reg(8'd9, 8'hC3);
        intr_active = 16'h0224;
        tick();
        intr_active = '0;
        chk("edge_lat_k", {31'd0, intr_valid}, 32'd0);
        tick();
        wait_grant("edge_g1", 4'd2);
        intr_serviced = 1'b1;
        intr_active   = 16'h0004;
        tick();
        intr_serviced = 1'b0;
        intr_active   = '0;
        chk("edge_ack1", {31'd0, intr_valid}, 32'd0);
        wait_grant("edge_g2", 4'd5);
        ack_clear(16'h0000);
        wait_grant("edge_g3", 4'd9);
        ack_clear(16'h0000);
        wait_grant("edge_g4", 4'd2);
        ack_clear(16'h0000);
        no_grant("edge_drained", 10);

        // Threshold: prio 7 blocked at THRESH=7, passes at THRESH=6
        do_reset();
        wr_reg(8'd3, 8'h87);
        wr_reg(8'd4, 8'h88);
        wr_reg(8'h80, 8'h07);
        intr_active = 16'h0018;
        wait_grant("thr_g1", 4'd4);
        ack_clear(16'h0010);
        no_grant("thr_block", 10);
        wr_reg(8'h80, 8'h06);
        wait_grant("thr_g2", 4'd3);
        ack_clear(16'h0008);
        intr_active = '0;

        // Register port: field masks, bad addresses, back-to-back access
        do_reset();
        wr_reg(8'd5, 8'hC5);
        apb(8'd5, 8'h00, 1'b0, rd, er);
        chk("cfg5_rd", {24'd0, rd}, 32'hC5);
        chk("cfg5_err", {31'd0, er}, 32'd0);
        wr_reg(8'd1, 8'hFF);
        apb(8'd1, 8'h00, 1'b0, rd, er);
        chk("cfg1_mask", {24'd0, rd}, 32'hCF);
        wr_reg(8'h80, 8'hFF);
        apb(8'h80, 8'h00, 1'b0, rd, er);
        chk("thresh_mask", {24'd0, rd}, 32'h0F);
        apb(8'h90, 8'h00, 1'b0, rd, er);
        chk("bad90_err", {31'd0, er}, 32'd1);
        chk("bad90_data", {24'd0, rd}, 32'h00);
        apb(8'h10, 8'h00, 1'b0, rd, er);
        chk("bad10_err", {31'd0, er}, 32'd1);
        apb(8'h0F, 8'h00, 1'b0, rd, er);
        chk("cfg15_err", {31'd0, er}, 32'd0);
        chk("cfg15_rd", {24'd0, rd}, 32'h00);
        paddr   = 8'd5;
        pwrite  = 1'b0;
        penable = 1'b1;
        tick();
        chk("b2b_rdy1", {31'd0, pready}, 32'd1);
        chk("b2b_data", {24'd0, prdata}, 32'hC5);
        tick();
        chk("b2b_gap", {31'd0, pready}, 32'd0);
        tick();
        chk("b2b_rdy2", {31'd0, pready}, 32'd1);
        penable = 1'b0;
        tick();
        chk("b2b_end", {31'd0, pready}, 32'd0);

        // Reset while servicing channel 6
        do_reset();
        wr_reg(8'd6, 8'h81);
        intr_active = 16'h0040;
        wait_grant("rst_svc", 4'd6);
        prst = 1'b1;
        tick();
        prst = 1'b0;
        chk("rst_mid_valid", {31'd0, intr_valid}, 32'd0);
        chk("rst_mid_id", {28'd0, intr_to_service}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            apb(8'(i), 8'h00, 1'b0, rd, er);
            chk("rst_cfg", {24'd0, rd}, 32'h00);
        end
        apb(8'h80, 8'h00, 1'b0, rd, er);
        chk("rst_thresh", {24'd0, rd}, 32'h00);
        no_grant("rst_quiet", 5);
        intr_active = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/prio_intr_ctrl.md
# prio_intr_ctrl

Parametrised, APB-programmable priority interrupt controller: the next generation of our fixed 16-source controller. It adds per-channel enable and edge/level mode, a global priority threshold, round-robin among equal priorities, a status register and an explicit service FSM. It sits between peripheral interrupt lines and the processor's service handshake on the APB bus.

## Interface
- NUM_INTR, 16, number of interrupt sources (2..64)
- PRIO_W, 4, priority field width (1..6)
- ID_W, $clog2(NUM_INTR), width of the serviced-channel id
- pclk_i  in  1  clock; all logic on rising edge
- prst_i  in  1  reset, synchronous, active-high
- paddr_i  in  8  APB address
- pwdata_i  in  8  APB write data
- pwrite_i  in  1  1 = write, 0 = read
- penable_i  in  1  access request
- prdata_o  out  8  read data, valid while pready_o=1
- pready_o  out  1  one-cycle access-complete pulse
- perror_o  out  1  access error, valid while pready_o=1
- intr_active_i  in  NUM_INTR  raw interrupt lines
- intr_serviced_i  in  1  processor acknowledges the current interrupt
- intr_to_service_o  out  ID_W  id of the interrupt being serviced
- intr_valid_o  out  1  intr_to_service_o is valid

## Operation
- Register map:
  - addr i (0..NUM_INTR-1) = CFG[i], read/write:
    - bits[PRIO_W-1:0] = priority
    - bit6 = edge mode (1 = rising edge, 0 = level)
    - bit7 = enable
    - other bits read 0
  - 0x80 = THRESH, read/write, bits[PRIO_W-1:0].
  - 0x81 = STATUS, read-only: bit7 = intr_valid_o, bits[5:0] = intr_to_service_o zero-extended.
- Any other address, or a write to 0x81: perror_o=1, no state change, prdata_o=0.
- APB:
  - On an edge where penable_i=1 and pready_o=0, the access executes: write committed, prdata_o/perror_o registered, pready_o=1 for exactly one cycle.
  - If the master holds penable_i high, the next access executes one cycle later. pready_o is never high two consecutive cycles.
- Pending:
  - Level channel: pending[i] = registered intr_active_i[i].
  - Edge channel: pending[i] is set on a 0->1 of intr_active_i[i] vs its registered previous value, and cleared when that channel's service completes. If set and clear coincide, set wins.
- Eligible[i] = pending[i] & enable[i] & (prio[i] > THRESH). With THRESH=0, priority-0 channels are never serviced.
- FSM states IDLE, SERVICE, DONE:
  - IDLE: if any channel is eligible, latch the winner into intr_to_service_o, set intr_valid_o=1, go to SERVICE.
  - SERVICE: hold the id. When intr_serviced_i=1, clear pending if the channel is edge mode, drop intr_valid_o, go to DONE. No preemption by a higher priority.
  - DONE: one cycle, lets level sources deassert, then go to IDLE.
  - intr_serviced_i outside SERVICE is ignored.
- Winner selection:
  - Highest priority wins.
  - Among equal priorities, round-robin: search starts at last_id+1 (mod NUM_INTR) and the first eligible found wins. last_id updates on service completion.
- Config writes during SERVICE take effect for the next arbitration. Disabling the in-service channel does not abort the current service.

## Timing
- Reset: all CFG=0 (disabled, level, prio 0), THRESH=0, pending=0, last_id=NUM_INTR-1, FSM=IDLE, prdata_o=0, pready_o=0, perror_o=0, intr_valid_o=0, intr_to_service_o=0.
- Reset asserted mid-service returns every register to its reset value on that edge.
- Interrupt latency:
  - Source rises before edge k; pending is set at edge k.
  - At edge k+1 the winner is latched and intr_valid_o=1.
- Service handshake:
  - intr_serviced_i sampled 1 at edge m: intr_valid_o=0 after m; DONE during m..m+1.
  - Next arbitration at edge m+2; next earliest intr_valid_o is after edge m+2.
- APB: penable_i sampled at edge j, pready_o high for cycle j..j+1.

## Test plan
- Program CFG[i]={en=1, level, prio=i} for i=0..15, THRESH=0, drive intr_active_i=16'h8421, ack each grant one cycle after intr_valid_o and deassert that source -> grant order 15, 10, 5. Channel 0 is never granted (prio 0).
- Channels 2, 5, 9 edge mode at prio 3, each pulsed once simultaneously; ack each grant -> order 2, 5, 9. A second pulse on 2 during its own SERVICE re-grants 2 after 9 completes.
- THRESH=7 with CFG[3].prio=7 and CFG[4].prio=8, both active -> only 4 is granted. Write THRESH=6 -> 3 is granted next.
- APB errors: read 0x90 -> perror_o=1, prdata_o=0. Write 0x81 -> perror_o=1 and STATUS unchanged. Read CFG[5] after writing 8'hC5 -> prdata_o=8'hC5.
- Assert prst_i for one cycle while in SERVICE on id 6 -> next cycle intr_valid_o=0, all CFG read 0.
- Latency check: edge-mode channel pulsed before edge k -> intr_valid_o=1 after edge k+1. Ack at edge m -> a still-pending channel is granted no earlier than after edge m+2.
